boa_peri_gpio_irq: RTL and testbench

// - Next-generation GPIO matrix peripheral on the boa_mem_bus peripheral bus.
// - Adds atomic OUT set/clear/toggle, per-byte write enables and a configurable input synchroniser.
// - Adds per-pin input/output inversion and per-pin edge interrupts with a W1C status register and a level IRQ output.
// - Sits beside the other peripherals on the bus; irq goes to the CPU interrupt controller.

---
 rtl/boa_peri_gpio_irq.sv | 124 ++++++++++++
 tb/tb_boa_peri_gpio_irq.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/boa_peri_gpio_irq.sv
// GPIO matrix peripheral: atomic OUT ops, per-pin inversion and ext-signal routing,
// synchronised inputs with per-pin edge interrupts (W1C status, level irq).
module boa_peri_gpio_irq #(
  parameter logic [31:0] addr    = 32'h8000_0000,
  parameter int          pins    = 32,
  parameter int          num_ext = 1,
  parameter int          sync    = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [29:0]          bus_addr,
  input  logic [3:0]           bus_we,
  input  logic [31:0]          bus_wdata,
  output logic [31:0]          bus_rdata,
  output logic                 bus_ready,
  input  logic [num_ext-1:0]   ext,
  input  logic [num_ext-1:0]   ext_oe,
  output logic [pins-1:0]      pin_out,
  output logic [pins-1:0]      pin_oe,
  input  logic [pins-1:0]      pin_in,
  output logic                 irq
);

  logic [pins-1:0] out_r, oe_r, irq_en, irq_rise, irq_fall, irq_stat;
  logic [18:0]     pincfg [pins];
  logic [pins-1:0] sync_q [sync];
  logic [pins-1:0] prev, s, in_inv, stat_set, stat_clr;
  logic [31:0]     wm, rd_nxt;
  logic [pins-1:0] wmp, wdp;
  logic [5:0]      word;
  logic            in_window;

  assign bus_ready = 1'b1;
  assign in_window = (bus_addr[29:6] == addr[31:8]);
  assign word      = bus_addr[5:0];

  // Byte-enable mask; zero outside the window so no register can change there.
  assign wm  = in_window ? {{8{bus_we[3]}}, {8{bus_we[2]}}, {8{bus_we[1]}}, {8{bus_we[0]}}} : 32'h0;
  assign wmp = wm[pins-1:0];
  assign wdp = bus_wdata[pins-1:0] & wmp;

  always_comb begin
    in_inv = '0;
    for (int n = 0; n < pins; n++) in_inv[n] = pincfg[n][18];
  end

  assign s        = sync_q[sync-1] ^ in_inv;
  assign stat_set = (s & ~prev & irq_rise) | (~s & prev & irq_fall);
  assign stat_clr = (word == 6'h09) ? wdp : '0;
  assign irq      = |(irq_stat & irq_en);

  // Per-pin output matrix; an out-of-range sel leaves only the inversion.
  always_comb begin
    pin_out = '0;
    pin_oe  = '0;
    for (int n = 0; n < pins; n++) begin
      if (pincfg[n][16]) begin
        pin_out[n] = pincfg[n][17];
        for (int j = 0; j < num_ext; j++) begin
          if (pincfg[n][15:0] == 16'(j)) begin
            pin_out[n] = ext[j] ^ pincfg[n][17];
            pin_oe[n]  = ext_oe[j];
          end
        end
      end else begin
        pin_out[n] = out_r[n] ^ pincfg[n][17];
        pin_oe[n]  = oe_r[n];
      end
    end
  end

  always_comb begin
    rd_nxt = '0;
    case (word)
      6'h00:   rd_nxt = 32'(out_r);
      6'h01:   rd_nxt = 32'(oe_r);
      6'h02:   rd_nxt = 32'(s);
      6'h06:   rd_nxt = 32'(irq_en);
      6'h07:   rd_nxt = 32'(irq_rise);
      6'h08:   rd_nxt = 32'(irq_fall);
      6'h09:   rd_nxt = 32'(irq_stat);
      default: ;
    endcase
    for (int n = 0; n < pins; n++)
      if (word == 6'(32 + n)) rd_nxt = 32'(pincfg[n]);
  end

  // Hardware edge set is OR'd after the W1C clear so it wins a same-cycle collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_r     <= '0;
      oe_r      <= '0;
      irq_en    <= '0;
      irq_rise  <= '0;
      irq_fall  <= '0;
      irq_stat  <= '0;
      prev      <= '0;
      bus_rdata <= '0;
      for (int n = 0; n < pins; n++) pincfg[n] <= '0;
      for (int i = 0; i < sync; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= pin_in;
      for (int i = 1; i < sync; i++) sync_q[i] <= sync_q[i-1];
      prev     <= s;
      irq_stat <= (irq_stat & ~stat_clr) | stat_set;
      if (in_window) bus_rdata <= rd_nxt;
      case (word)
        6'h00:   out_r    <= (out_r & ~wmp) | wdp;
        6'h01:   oe_r     <= (oe_r & ~wmp) | wdp;
        6'h03:   out_r    <= out_r | wdp;
        6'h04:   out_r    <= out_r & ~wdp;
        6'h05:   out_r    <= out_r ^ wdp;
        6'h06:   irq_en   <= (irq_en & ~wmp) | wdp;
        6'h07:   irq_rise <= (irq_rise & ~wmp) | wdp;
        6'h08:   irq_fall <= (irq_fall & ~wmp) | wdp;
        default: ;
      endcase
      for (int n = 0; n < pins; n++)
        if (word == 6'(32 + n))
          pincfg[n] <= (pincfg[n] & ~wm[18:0]) | (bus_wdata[18:0] & wm[18:0]);
    end
  end

endmodule

// File: tb/tb_boa_peri_gpio_irq.sv
// Directed self-checking bench for boa_peri_gpio_irq (pins=32, num_ext=4, sync=2).
module tb_boa_peri_gpio_irq;

  localparam logic [31:0] BASE = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [29:0] bus_addr = '0;
  logic [3:0]  bus_we = '0;
  logic [31:0] bus_wdata = '0;
  logic [31:0] bus_rdata;
  logic        bus_ready;
  logic [3:0]  ext = '0;
  logic [3:0]  ext_oe = '0;
  logic [31:0] pin_out, pin_oe;
  logic [31:0] pin_in = '1;
  logic        irq;

  int passed = 0;
  int total  = 0;
  logic [31:0] rd;

  always #5 clk = ~clk;

  boa_peri_gpio_irq #(.addr(BASE), .pins(32), .num_ext(4), .sync(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .bus_addr(bus_addr), .bus_we(bus_we), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_ready(bus_ready),
    .ext(ext), .ext_oe(ext_oe),
    .pin_out(pin_out), .pin_oe(pin_oe), .pin_in(pin_in), .irq(irq)
  );

  task automatic bus_write(input logic [7:0] off, input logic [31:0] d, input logic [3:0] we);
    @(negedge clk);
    bus_addr  = 30'((BASE + 32'(off)) >> 2);
    bus_we    = we;
    bus_wdata = d;
    @(negedge clk);
    bus_we   = '0;
    bus_addr = '0;
  endtask

  task automatic bus_read(input logic [7:0] off, output logic [31:0] d);
    @(negedge clk);
    bus_addr = 30'((BASE + 32'(off)) >> 2);
    bus_we   = '0;
    @(negedge clk);
    d        = bus_rdata;
    bus_addr = '0;
  endtask

  task automatic test_reset;
    #3;
    total++; if (pin_out !== 32'h0) $display("[TB] FAIL reset_pin_out got %h want 0", pin_out); else passed++;
    total++; if (pin_oe !== 32'h0) $display("[TB] FAIL reset_pin_oe got %h want 0", pin_oe); else passed++;
    total++; if (irq !== 1'b0) $display("[TB] FAIL reset_irq got %b want 0", irq); else passed++;
    total++; if (bus_rdata !== 32'h0) $display("[TB] FAIL reset_rdata got %h want 0", bus_rdata); else passed++;
    total++; if (bus_ready !== 1'b1) $display("[TB] FAIL ready got %b want 1", bus_ready); else passed++;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    bus_read(8'h08, rd);
    total++; if (rd !== 32'hFFFF_FFFF) $display("[TB] FAIL reset_in got %h want ffffffff", rd); else passed++;
    bus_read(8'h24, rd);
    total++; if (rd !== 32'h0) $display("[TB] FAIL reset_stat got %h want 0", rd); else passed++;
  endtask

  task automatic test_atomic;
    pin_in = '0;
    repeat (4) @(negedge clk);
    bus_write(8'h00, 32'h0000_00F0, 4'hF);
    bus_write(8'h0C, 32'h0000_000F, 4'hF);
    bus_write(8'h10, 32'h0000_0030, 4'hF);
    bus_write(8'h14, 32'h0000_0101, 4'b0001);
    bus_read(8'h00, rd);
    total++; if (rd !== 32'h0000_00CE) $display("[TB] FAIL atomic_out got %h want 000000ce", rd); else passed++;
    total++; if (pin_out !== 32'h0000_00CE) $display("[TB] FAIL atomic_pin_out got %h want 000000ce", pin_out); else passed++;
    bus_write(8'h00, 32'hAABB_CCDD, 4'b0100);
    bus_read(8'h00, rd);
    total++; if (rd !== 32'h00BB_00CE) $display("[TB] FAIL byte_en_out got %h want 00bb00ce", rd); else passed++;
    @(negedge clk);
    total++; if (bus_rdata !== 32'h00BB_00CE) $display("[TB] FAIL rdata_hold got %h want 00bb00ce", bus_rdata); else passed++;
    bus_write(8'h04, 32'h0000_00FF, 4'hF);
    total++; if (pin_oe !== 32'h0000_00FF) $display("[TB] FAIL oe_pin got %h want 000000ff", pin_oe); else passed++;
    bus_read(8'h0C, rd);
    total++; if (rd !== 32'h0) $display("[TB] FAIL set_reads_zero got %h want 0", rd); else passed++;
    bus_write(8'h40, 32'hFFFF_FFFF, 4'hF);
    bus_read(8'h40, rd);
    total++; if (rd !== 32'h0) $display("[TB] FAIL unmapped got %h want 0", rd); else passed++;
  endtask

  task automatic test_matrix;
    ext    = 4'b0100;
    ext_oe = 4'b0100;
    bus_write(8'h8C, 32'h0003_0002, 4'hF);
    total++; if (pin_out[3] !== 1'b0) $display("[TB] FAIL matrix_out got %b want 0", pin_out[3]); else passed++;
    total++; if (pin_oe[3] !== 1'b1) $display("[TB] FAIL matrix_oe got %b want 1", pin_oe[3]); else passed++;
    bus_read(8'h8C, rd);
    total++; if (rd !== 32'h0003_0002) $display("[TB] FAIL pincfg_read got %h want 00030002", rd); else passed++;
    bus_write(8'h8C, 32'h0003_0007, 4'hF);
    total++; if (pin_out[3] !== 1'b1) $display("[TB] FAIL matrix_oor_out got %b want 1", pin_out[3]); else passed++;
    total++; if (pin_oe[3] !== 1'b0) $display("[TB] FAIL matrix_oor_oe got %b want 0", pin_oe[3]); else passed++;
    bus_write(8'h8C, 32'h0, 4'hF);
  endtask

  task automatic test_edge_irq;
    bus_write(8'h1C, 32'h1, 4'hF);
    bus_write(8'h18, 32'h1, 4'hF);
    pin_in[0] = 1'b1;
    @(negedge clk);
    pin_in[0] = 1'b0;
    total++; if (irq !== 1'b0) $display("[TB] FAIL irq_early1 got %b want 0", irq); else passed++;
    @(negedge clk);
    total++; if (irq !== 1'b0) $display("[TB] FAIL irq_early2 got %b want 0", irq); else passed++;
    @(negedge clk);
    total++; if (irq !== 1'b1) $display("[TB] FAIL irq_k2 got %b want 1", irq); else passed++;
    bus_read(8'h24, rd);
    total++; if (rd !== 32'h1) $display("[TB] FAIL stat_set got %h want 1", rd); else passed++;
    bus_write(8'h24, 32'h1, 4'b0010);
    total++; if (irq !== 1'b1) $display("[TB] FAIL w1c_masked got %b want 1", irq); else passed++;
    bus_write(8'h24, 32'h1, 4'hF);
    total++; if (irq !== 1'b0) $display("[TB] FAIL w1c_irq got %b want 0", irq); else passed++;
    bus_read(8'h24, rd);
    total++; if (rd !== 32'h0) $display("[TB] FAIL w1c_stat got %h want 0", rd); else passed++;
  endtask

  task automatic test_collision;
    bus_write(8'h20, 32'h20, 4'hF);
    pin_in[5] = 1'b1;
    repeat (4) @(negedge clk);
    pin_in[5] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    bus_addr  = 30'((BASE + 32'h24) >> 2);
    bus_we    = 4'hF;
    bus_wdata = 32'h20;
    @(negedge clk);
    bus_we   = '0;
    bus_addr = '0;
    bus_read(8'h24, rd);
    total++; if (rd !== 32'h20) $display("[TB] FAIL collision got %h want 00000020", rd); else passed++;
    bus_write(8'h24, 32'h20, 4'hF);
    bus_read(8'h24, rd);
    total++; if (rd !== 32'h0) $display("[TB] FAIL collision_clr got %h want 0", rd); else passed++;
  endtask

  task automatic test_async_reset;
    pin_in[0] = 1'b1;
    @(negedge clk);
    pin_in[0] = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (irq !== 1'b1) $display("[TB] FAIL pre_reset_irq got %b want 1", irq); else passed++;
    bus_read(8'h00, rd);
    total++; if (rd !== 32'h00BB_00CE) $display("[TB] FAIL pre_reset_out got %h want 00bb00ce", rd); else passed++;
    @(negedge clk);
    bus_addr  = 30'(BASE >> 2);
    bus_we    = 4'hF;
    bus_wdata = 32'h0000_1234;
    #2;
    rst_n  = 1'b0;
    pin_in = '1;
    #1;
    total++; if (irq !== 1'b0) $display("[TB] FAIL async_irq got %b want 0", irq); else passed++;
    total++; if (pin_out !== 32'h0) $display("[TB] FAIL async_out got %h want 0", pin_out); else passed++;
    total++; if (pin_oe !== 32'h0) $display("[TB] FAIL async_oe got %h want 0", pin_oe); else passed++;
    total++; if (bus_rdata !== 32'h0) $display("[TB] FAIL async_rdata got %h want 0", bus_rdata); else passed++;
    repeat (2) @(negedge clk);
    bus_we   = '0;
    bus_addr = '0;
    rst_n    = 1'b1;
    repeat (5) @(negedge clk);
    total++; if (irq !== 1'b0) $display("[TB] FAIL post_irq got %b want 0", irq); else passed++;
    bus_read(8'h24, rd);
    total++; if (rd !== 32'h0) $display("[TB] FAIL post_stat got %h want 0", rd); else passed++;
    bus_read(8'h00, rd);
    total++; if (rd !== 32'h0) $display("[TB] FAIL post_out got %h want 0", rd); else passed++;
  endtask

  initial begin
    test_reset;
    test_atomic;
    test_matrix;
    test_edge_irq;
    test_collision;
    test_async_reset;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
